// File: rtl/decimating_averager_pkg.sv
`default_nettype none
// ============================================================================
// Module   : decimating_averager_pkg
// Brief    : Shared widths, state encoding and exponent clamp for the averager.
// Revision : 1.0
// ============================================================================
package decimating_averager_pkg;

    localparam int DATA_W     = 32;
    localparam int MAX_LOG2_N = 10;
    localparam int ACC_W      = DATA_W + MAX_LOG2_N;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    function automatic logic [3:0] clamp_log2(input logic [3:0] v, input logic [3:0] max_v);
        return (v > max_v) ? max_v : v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/decimating_averager.sv
`default_nettype none
// ============================================================================
// Module   : decimating_averager
// Brief    : Sums 2^log2_n signed samples per frame and emits the floored mean.
// Revision : 1.0
// ============================================================================
module decimating_averager #(
    parameter int DATA_W     = decimating_averager_pkg::DATA_W,
    parameter int MAX_LOG2_N = decimating_averager_pkg::MAX_LOG2_N
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_in_valid,
    input  logic [3:0]        log2_n,
    output logic [DATA_W-1:0] data_out,
    output logic              data_out_valid,
    output logic [31:0]       frame_count,
    output logic              busy
);
    import decimating_averager_pkg::*;

    localparam int ACC_WIDTH = DATA_W + MAX_LOG2_N;
    localparam int CNT_W     = MAX_LOG2_N + 1;

    state_t                       state_q, state_d;
    logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic [3:0]                   log2_q, log2_d;
    logic [DATA_W-1:0]            data_out_q, data_out_d;
    logic                         data_out_valid_q, data_out_valid_d;
    logic [31:0]                  frame_count_q, frame_count_d;

    logic                         accept;
    logic [3:0]                   eff_log2;
    logic signed [ACC_WIDTH-1:0]  base_acc;
    logic signed [ACC_WIDTH-1:0]  sample_ext;
    logic signed [ACC_WIDTH-1:0]  sum;
    logic [CNT_W-1:0]             base_cnt;
    logic [CNT_W-1:0]             cnt_inc;
    logic [CNT_W-1:0]             frame_len;

    always_comb begin
        accept     = enable & data_in_valid;
        // The exponent is sampled only when a frame opens; mid-frame it comes from the latch.
        eff_log2   = (state_q == IDLE) ? clamp_log2(log2_n, 4'(MAX_LOG2_N)) : log2_q;
        base_acc   = (state_q == ACCUM) ? acc_q : '0;
        base_cnt   = (state_q == ACCUM) ? cnt_q : '0;
        sample_ext = {{MAX_LOG2_N{data_in[DATA_W-1]}}, data_in};
        sum        = base_acc + sample_ext;
        cnt_inc    = base_cnt + CNT_W'(1);
        frame_len  = CNT_W'(1) << eff_log2;

        state_d          = state_q;
        acc_d            = acc_q;
        cnt_d            = cnt_q;
        log2_d           = log2_q;
        data_out_d       = data_out_q;
        data_out_valid_d = 1'b0;
        frame_count_d    = frame_count_q;

        if (accept) begin
            log2_d = eff_log2;
            if (cnt_inc == frame_len) begin
                state_d          = IDLE;
                acc_d            = '0;
                cnt_d            = '0;
                data_out_d       = DATA_W'(sum >>> eff_log2);
                data_out_valid_d = 1'b1;
                frame_count_d    = frame_count_q + 32'd1;
            end else begin
                state_d = ACCUM;
                acc_d   = sum;
                cnt_d   = cnt_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= IDLE;
            acc_q            <= '0;
            cnt_q            <= '0;
            log2_q           <= '0;
            data_out_q       <= '0;
            data_out_valid_q <= 1'b0;
            frame_count_q    <= '0;
        end else begin
            state_q          <= state_d;
            acc_q            <= acc_d;
            cnt_q            <= cnt_d;
            log2_q           <= log2_d;
            data_out_q       <= data_out_d;
            data_out_valid_q <= data_out_valid_d;
            frame_count_q    <= frame_count_d;
        end
    end

    assign data_out       = data_out_q;
    assign data_out_valid = data_out_valid_q;
    assign frame_count    = frame_count_q;
    assign busy           = (state_q == ACCUM);

endmodule
`default_nettype wire

// File: tb/tb_decimating_averager.sv
`default_nettype none
// ============================================================================
// Module   : tb_decimating_averager
// Brief    : Directed self-checking bench for decimating_averager.
// Revision : 1.0
// ============================================================================
module tb_decimating_averager;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [31:0] data_in;
    logic        data_in_valid;
    logic [3:0]  log2_n;
    logic [31:0] data_out;
    logic        data_out_valid;
    logic [31:0] frame_count;
    logic        busy;

    int checks;
    int errors;

    decimating_averager #(
        .DATA_W     (32),
        .MAX_LOG2_N (10)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .data_in        (data_in),
        .data_in_valid  (data_in_valid),
        .log2_n         (log2_n),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .frame_count    (frame_count),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Present inputs, take one rising edge, then settle so outputs are sampled off-edge.
    task automatic step(input logic en, input logic v, input logic [31:0] d);
        enable        = en;
        data_in_valid = v;
        data_in       = d;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b0, 32'd0);
        reset = 1'b0;
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        reset         = 1'b1;
        enable        = 1'b0;
        data_in       = '0;
        data_in_valid = 1'b0;
        log2_n        = 4'd0;
        @(negedge clk);
        do_reset();

        chk("rst_data_out", data_out, 32'd0);
        chk("rst_valid", {31'd0, data_out_valid}, 32'd0);
        chk("rst_frame_count", frame_count, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);

        // Four samples averaged to 10; enable drops right after the last one.
        log2_n = 4'd2;
        step(1'b1, 1'b1, 32'd4);
        chk("f1_busy_open", {31'd0, busy}, 32'd1);
        step(1'b1, 1'b1, 32'd8);
        step(1'b1, 1'b1, 32'd12);
        chk("f1_no_early", {31'd0, data_out_valid}, 32'd0);
        step(1'b1, 1'b1, 32'd16);
        chk("f1_valid", {31'd0, data_out_valid}, 32'd1);
        chk("f1_data", data_out, 32'd10);
        chk("f1_count", frame_count, 32'd1);
        chk("f1_busy_closed", {31'd0, busy}, 32'd0);
        step(1'b0, 1'b1, 32'd99);
        chk("f1_pulse_single", {31'd0, data_out_valid}, 32'd0);
        chk("f1_hold", data_out, 32'd10);

        // Negative sum floors: -5/4 -> -2; then two back-to-back frames of 1..8.
        do_reset();
        log2_n = 4'd2;
        step(1'b1, 1'b1, 32'hFFFF_FFFF);
        step(1'b1, 1'b1, 32'hFFFF_FFFF);
        step(1'b1, 1'b1, 32'hFFFF_FFFF);
        step(1'b1, 1'b1, 32'hFFFF_FFFE);
        chk("neg_data", data_out, 32'hFFFF_FFFE);
        chk("neg_valid", {31'd0, data_out_valid}, 32'd1);
        do_reset();
        step(1'b1, 1'b1, 32'd1);
        step(1'b1, 1'b1, 32'd2);
        step(1'b1, 1'b1, 32'd3);
        step(1'b1, 1'b1, 32'd4);
        chk("b2b_first_valid", {31'd0, data_out_valid}, 32'd1);
        chk("b2b_first_data", data_out, 32'd2);
        step(1'b1, 1'b1, 32'd5);
        chk("b2b_gap_low", {31'd0, data_out_valid}, 32'd0);
        chk("b2b_busy_new", {31'd0, busy}, 32'd1);
        step(1'b1, 1'b1, 32'd6);
        step(1'b1, 1'b1, 32'd7);
        step(1'b1, 1'b1, 32'd8);
        chk("b2b_second_valid", {31'd0, data_out_valid}, 32'd1);
        chk("b2b_second_data", data_out, 32'd6);
        chk("b2b_count", frame_count, 32'd2);

        // Enable gap after the third of eight samples of 100; ignored valid during gap.
        do_reset();
        log2_n = 4'd3;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 32'd100);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 32'd5000);
            chk("gap_busy", {31'd0, busy}, 32'd1);
        end
        chk("gap_no_pulse", {31'd0, data_out_valid}, 32'd0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 32'd100);
        chk("gap_seventh_no_pulse", {31'd0, data_out_valid}, 32'd0);
        step(1'b1, 1'b1, 32'd100);
        chk("gap_valid", {31'd0, data_out_valid}, 32'd1);
        chk("gap_data", data_out, 32'd100);
        chk("gap_count", frame_count, 32'd1);

        // Exponent change mid-frame only affects the following frame.
        do_reset();
        log2_n = 4'd1;
        step(1'b1, 1'b1, 32'd10);
        log2_n = 4'd3;
        step(1'b1, 1'b1, 32'd20);
        chk("lat_valid", {31'd0, data_out_valid}, 32'd1);
        chk("lat_data", data_out, 32'd15);
        step(1'b1, 1'b1, 32'd1);
        step(1'b1, 1'b1, 32'd2);
        chk("lat_n8_no_early", {31'd0, data_out_valid}, 32'd0);
        for (int i = 3; i <= 7; i++) step(1'b1, 1'b1, 32'(i));
        chk("lat_n8_seventh", {31'd0, data_out_valid}, 32'd0);
        step(1'b1, 1'b1, 32'd8);
        chk("lat_n8_valid", {31'd0, data_out_valid}, 32'd1);
        chk("lat_n8_data", data_out, 32'd4);

        // Reset mid-frame drops the partial sum with no pulse.
        do_reset();
        log2_n = 4'd2;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 32'd9);
        reset = 1'b1;
        step(1'b1, 1'b1, 32'd9);
        reset = 1'b0;
        chk("mid_rst_valid", {31'd0, data_out_valid}, 32'd0);
        chk("mid_rst_data", data_out, 32'd0);
        chk("mid_rst_count", frame_count, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        step(1'b0, 1'b0, 32'd0);
        chk("mid_rst_quiet", {31'd0, data_out_valid}, 32'd0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 32'd7);
        chk("mid_rst_new_data", data_out, 32'd7);
        chk("mid_rst_new_count", frame_count, 32'd1);

        // Oversized exponent clamps to 1024 samples of full-scale positive.
        do_reset();
        log2_n = 4'd15;
        for (int i = 0; i < 1023; i++) step(1'b1, 1'b1, 32'h7FFF_FFFF);
        chk("clamp_1023_no_pulse", {31'd0, data_out_valid}, 32'd0);
        chk("clamp_1023_busy", {31'd0, busy}, 32'd1);
        step(1'b1, 1'b1, 32'h7FFF_FFFF);
        chk("clamp_valid", {31'd0, data_out_valid}, 32'd1);
        chk("clamp_data", data_out, 32'h7FFF_FFFF);

        // Pass-through with N=1: one pulse per sample, one cycle late.
        log2_n = 4'd0;
        step(1'b1, 1'b1, 32'd5);
        chk("pass_first_valid", {31'd0, data_out_valid}, 32'd1);
        chk("pass_first_data", data_out, 32'd5);
        chk("pass_busy", {31'd0, busy}, 32'd0);
        step(1'b1, 1'b1, 32'hFFFF_FFFD);
        chk("pass_second_valid", {31'd0, data_out_valid}, 32'd1);
        chk("pass_second_data", data_out, 32'hFFFF_FFFD);
        chk("pass_count", frame_count, 32'd3);
        step(1'b0, 1'b0, 32'd0);
        chk("pass_idle", {31'd0, data_out_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
